pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register, the generic successor to the fixed ID/EX latch. It carries a `WIDTH`-bit payload between two pipeline stages with a valid/ready handshake. It supports flush to a zero bubble and keeps a saturating stall-cycle counter for performance monitoring. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage's control bundle packed into the payload.

---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/pipe_sat_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage registers.
package pipe_pkg;

  localparam int unsigned PIPE_CNT_W_DEFAULT = 16;
  localparam int unsigned PIPE_OCC_W         = 2;

  // Stage fill level; the encoding doubles as the occupancy output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // IF/ID boundary payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_payload_t;

  // ID/EX boundary payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_payload_t;

  // EX/MEM boundary payload.
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_payload_t;

  // MEM/WB boundary payload.
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up on inc, stick at the maximum, clear wins over inc.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush and stall counter.
// Build option: define PIPE_SKID_EN for the two-entry skid buffer with a
// registered in_ready; otherwise a single entry whose in_ready follows
// out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [PIPE_OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  stage_state_t     state;
  logic [WIDTH-1:0] head_q;
  logic             out_valid_q;
  logic             push;
  logic             pop;
  logic             stall;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign push      = in_valid && in_ready;
  assign pop       = out_valid_q && out_ready;
  assign stall     = out_valid_q && !out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign occupancy = PIPE_OCC_W'(state);

`ifdef PIPE_SKID_EN
  // Two-entry skid buffer: head feeds the output, skid absorbs one extra beat.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state       <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_q      <= in_data;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (pop) begin
            head_q      <= '0;
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q     <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          head_q      <= '0;
          skid_q      <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end
`else
  // Single entry: a new beat is only taken when the slot empties this cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= EMPTY;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_q      <= in_data;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push) begin
            head_q <= in_data;
          end else if (pop) begin
            head_q      <= '0;
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        default: begin
          state       <= EMPTY;
          head_q      <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
`endif

  // Back-pressure monitor; survives flush, cleared only by reset.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (stall),
    .clr   (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (works with or without PIPE_SKID_EN).
module tb_pipe_stage_reg;

  logic        clk;
  logic        n_rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        d2_in_ready;
  logic        d2_out_valid;
  logic [31:0] d2_out_data;
  logic [1:0]  d2_occupancy;
  logic [2:0]  d2_stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  int          stall_m = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[11];

  pipe_stage_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(32), .CNT_W(3)) dut_c3 (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (d2_in_ready),
    .in_data   (in_data),
    .out_valid (d2_out_valid),
    .out_ready (out_ready),
    .out_data  (d2_out_data),
    .occupancy (d2_occupancy),
    .stall_cnt (d2_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // One cycle: drive inputs, check against the model, update the model, advance.
  task automatic step(input logic fl, input logic iv, input logic [31:0] id,
                      input logic ordy, output logic pushed);
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        pop;
    int          s16;
    int          s3;
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    e_valid = (exp_q.size() != 0);
    e_data  = e_valid ? exp_q[0] : 32'h0;
`ifdef PIPE_SKID_EN
    e_rdy = (exp_q.size() != 2);
`else
    e_rdy = !e_valid || ordy;
`endif
    s16 = (stall_m > 65535) ? 65535 : stall_m;
    s3  = (stall_m > 7) ? 7 : stall_m;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_data", 64'(out_data), 64'(e_data));
    chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("stall_cnt", 64'(stall_cnt), 64'(s16));
    chk("c3_out_data", 64'(d2_out_data), 64'(e_data));
    chk("c3_out_valid", 64'(d2_out_valid), 64'(e_valid));
    chk("c3_occupancy", 64'(d2_occupancy), 64'(exp_q.size()));
    chk("c3_in_ready", 64'(d2_in_ready), 64'(e_rdy));
    chk("c3_stall_cnt", 64'(d2_stall_cnt), 64'(s3));
    pushed = iv && e_rdy;
    pop    = e_valid && ordy;
    if (pop) pop_log.push_back(exp_q[0]);
    if (e_valid && !ordy) stall_m++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (pushed) exp_q.push_back(id);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic        p;
    int          ptr;
    int          s0;
    logic [31:0] vals[3];

    n_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Streaming at full rate: DEADBEEF then 1..8, each visible one cycle later.
    vecs[0]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 32'hDEADBEEF, 2'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 32'h1, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 32'h2, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h3, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h5, 1'b1, 1'b1, 32'h4, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h6, 1'b1, 1'b1, 32'h5, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h7, 1'b1, 1'b1, 32'h6, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 32'h7, 2'd1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].id;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      @(posedge clk); #1;
    end

    // Back-pressure then release: order must be 1, 2, 3.
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    pop_log.delete();
    ptr = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(1'b0, ptr < 3, (ptr < 3) ? vals[ptr] : 32'h0, cyc >= 3, p);
      if (p) ptr++;
    end
    chk("order_count", 64'(pop_log.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("order_%0d", i), 64'((pop_log.size() > i) ? pop_log[i] : 32'hFFFF_FFFF),
          64'(vals[i]));

    // Flush with a (possibly) full stage and a live input beat.
    step(1'b0, 1'b1, 32'hA, 1'b0, p);
    step(1'b0, 1'b1, 32'hB, 1'b0, p);
    step(1'b1, 1'b1, 32'h55, 1'b0, p);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, p);

    // Stall counter: +5, then saturation of the 3-bit instance.
    step(1'b0, 1'b1, 32'h77, 1'b0, p);
    s0 = stall_m;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, p);
    chk("stall_plus5", 64'(stall_cnt), 64'(s0 + 5));
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, p);
    chk("stall_sat_c3", 64'(d2_stall_cnt), 64'd7);
    step(1'b1, 1'b0, 32'h0, 1'b0, p);
    chk("stall_kept_by_flush", 64'(stall_cnt), 64'(stall_m));
    step(1'b0, 1'b0, 32'h0, 1'b1, p);

    // Asynchronous reset mid-stream.
    step(1'b0, 1'b1, 32'h11, 1'b0, p);
    step(1'b0, 1'b1, 32'h22, 1'b0, p);
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    exp_q.delete();
    stall_m = 0;
    step(1'b0, 1'b1, 32'h33, 1'b1, p);
    step(1'b0, 1'b0, 32'h0, 1'b1, p);

    // Random traffic with occasional flush against the queue model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 99) < 5, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 2) != 0, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
